feature_map_collector: RTL and testbench

//  Receiver at the output end of the conv/pooling chain. Accepts the sparse per-kernel
//  out_valid / out_data[PE lanes] stream of the last conv_pooling_layer and stores each

---
 rtl/feature_map_collector_pkg.sv | 20 ++
 rtl/fmap_bank.sv | 31 +++
 rtl/feature_map_collector.sv | 153 +++++++++++++++
 tb/tb_feature_map_collector.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/feature_map_collector_pkg.sv
// Shared types and width helpers for the feature map collector.
package feature_map_collector_pkg;

  typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_state_t;

  function automatic int popcount(input logic [31:0] v);
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(v[i]);
    return n;
  endfunction

  function automatic int addr_width(input int k, input int p);
    return (k * p > 1) ? $clog2(k * p) : 1;
  endfunction

  function automatic int cnt_width(input int p);
    return $clog2(p + 1);
  endfunction

endpackage

// File: rtl/fmap_bank.sv
// One feature-map bank: multi-lane write ports, one registered read port.
module fmap_bank #(
  parameter int Lanes = 2,
  parameter int DataW = 32,
  parameter int Depth = 16,
  parameter int AW    = 4
) (
  input  logic                        clk,
  input  logic                        res_n,
  input  logic [Lanes-1:0]            we,
  input  logic [Lanes-1:0][AW-1:0]    waddr,
  input  logic [Lanes-1:0][DataW-1:0] wdata,
  input  logic                        re,
  input  logic [AW-1:0]               raddr,
  output logic [DataW-1:0]            rdata
);

  logic [DataW-1:0] mem [Depth];

  // Lanes always carry distinct kernels, so write addresses never collide.
  always_ff @(posedge clk) begin
    for (int l = 0; l < Lanes; l++)
      if (we[l]) mem[waddr[l]] <= wdata[l];
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/feature_map_collector.sv
// Collects per-kernel pooled maps into ping-pong banks and drains each full
// bank as one serial valid/ready pixel stream.
module feature_map_collector
  import feature_map_collector_pkg::*;
#(
  parameter int BitSize            = 32,
  parameter int NumberOfK          = 4,
  parameter int ProcessingElements = 2,
  parameter int OutWidth           = 2
) (
  input  logic                                      clk,
  input  logic                                      res_n,
  input  logic [NumberOfK-1:0]                      in_valid,
  input  logic [ProcessingElements-1:0][BitSize-1:0] in_data,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [BitSize-1:0]                        out_data,
  output logic [$clog2(NumberOfK)-1:0]              out_kernel,
  output logic                                      out_last,
  output logic                                      image_done,
  output logic                                      overflow
);

  localparam int PE    = ProcessingElements;
  localparam int P     = OutWidth * OutWidth;
  localparam int DEPTH = NumberOfK * P;
  localparam int AW    = addr_width(NumberOfK, P);
  localparam int CW    = cnt_width(P);
  localparam int KW    = $clog2(NumberOfK);

  bank_state_t                st [2];
  bank_state_t                st_n [2];
  logic                       wr_bank, rd_bank;
  logic [CW-1:0]              cnt [NumberOfK];
  logic [CW-1:0]              cnt_n [NumberOfK];
  logic [AW-1:0]              rd_addr, raddr;
  logic [1:0]                 re;
  logic [PE-1:0]              we;
  logic [PE-1:0][AW-1:0]      waddr;
  logic [PE-1:0][BitSize-1:0] wdata;
  logic [1:0][BitSize-1:0]    rdata;
  logic                       wr_ok, any_acc, all_full, full_now, drop, rd_done;

  assign wr_ok    = (st[wr_bank] == EMPTY) || (st[wr_bank] == FILLING);
  assign full_now = wr_ok && any_acc && all_full;

  // Set in_valid bits claim lanes in ascending kernel order; extras are dropped.
  always_comb begin
    int lane;
    lane     = 0;
    we       = '0;
    waddr    = '0;
    wdata    = '0;
    any_acc  = 1'b0;
    all_full = 1'b1;
    drop     = popcount(32'(in_valid)) > PE;
    for (int k = 0; k < NumberOfK; k++) begin
      cnt_n[k] = cnt[k];
      if (in_valid[k] && lane < PE) begin
        if (wr_ok && cnt[k] != CW'(P)) begin
          for (int l = 0; l < PE; l++)
            if (l == lane) begin
              we[l]    = 1'b1;
              waddr[l] = AW'(k * P + int'(cnt[k]));
              wdata[l] = in_data[l];
            end
          cnt_n[k] = cnt[k] + 1'b1;
          any_acc  = 1'b1;
        end else begin
          drop = 1'b1;
        end
        lane++;
      end
      if (cnt_n[k] != CW'(P)) all_full = 1'b0;
    end
  end

  // Write side only moves EMPTY/FILLING banks, read side only FULL/DRAINING.
  always_comb begin
    st_n    = st;
    re      = '0;
    raddr   = rd_addr;
    rd_done = 1'b0;
    if (wr_ok && any_acc) st_n[wr_bank] = full_now ? FULL : FILLING;
    if (!out_valid) begin
      if (st[rd_bank] == FULL) begin
        re[rd_bank]   = 1'b1;
        raddr         = '0;
        st_n[rd_bank] = DRAINING;
      end
    end else if (out_ready) begin
      if (out_last) begin
        rd_done       = 1'b1;
        st_n[rd_bank] = EMPTY;
        if (st[!rd_bank] == FULL) begin
          re[!rd_bank]   = 1'b1;
          raddr          = '0;
          st_n[!rd_bank] = DRAINING;
        end
      end else begin
        re[rd_bank] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      st[0]      <= EMPTY;
      st[1]      <= EMPTY;
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      rd_addr    <= '0;
      for (int k = 0; k < NumberOfK; k++) cnt[k] <= '0;
      image_done <= 1'b0;
      overflow   <= 1'b0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_kernel <= '0;
    end else begin
      st         <= st_n;
      image_done <= full_now;
      for (int k = 0; k < NumberOfK; k++) cnt[k] <= full_now ? '0 : cnt_n[k];
      if (full_now) wr_bank  <= !wr_bank;
      if (drop)     overflow <= 1'b1;
      if (rd_done)  rd_bank  <= !rd_bank;
      if (|re) begin
        out_valid  <= 1'b1;
        out_kernel <= KW'(int'(raddr) / P);
        out_last   <= (int'(raddr) == DEPTH - 1);
        rd_addr    <= raddr + 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fmap_bank #(.Lanes(PE), .DataW(BitSize), .Depth(DEPTH), .AW(AW)) u_bank (
      .clk   (clk),
      .res_n (res_n),
      .we    (we & {PE{wr_bank == 1'(b)}}),
      .waddr (waddr),
      .wdata (wdata),
      .re    (re[b]),
      .raddr (raddr),
      .rdata (rdata[b])
    );
  end

  assign out_data = rdata[rd_bank];

endmodule

// File: tb/tb_feature_map_collector.sv
// Directed/randomized bench for feature_map_collector against an image-level model.
module tb_feature_map_collector;

  localparam int K = 4, PE = 2, P = 4, N = K * P;

  logic                 clk = 1'b0;
  logic                 res_n;
  logic [K-1:0]         in_valid;
  logic [PE-1:0][31:0]  in_data;
  logic                 out_valid, out_ready, out_last, image_done, overflow;
  logic [31:0]          out_data;
  logic [1:0]           out_kernel;

  feature_map_collector dut (
    .clk(clk), .res_n(res_n), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_kernel(out_kernel), .out_last(out_last), .image_done(image_done),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] d; logic [1:0] k; logic l; } beat_t;
  typedef struct { logic [31:0] d; logic [1:0] k; logic l; int cyc; } obs_t;

  int     tests = 0, fails = 0, cyc = 0, rmode = 0, held = 0;
  int     mcnt [K];
  logic [31:0] img [N];
  logic   exp_ovf = 1'b0;
  beat_t  exp_q[$];
  obs_t   obs_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Image-level model: lane mapping, per-kernel caps, two-image buffering limit.
  function automatic void model_write(input logic [3:0] v, input logic [1:0][31:0] d);
    int  lane = 0;
    bit  done = 1'b1;
    for (int k = 0; k < K; k++) if (v[k]) begin
      if (lane >= PE || held >= 2 || mcnt[k] == P) exp_ovf = 1'b1;
      else begin
        img[k * P + mcnt[k]] = d[lane[0]];
        mcnt[k]++;
      end
      lane++;
    end
    for (int k = 0; k < K; k++) if (mcnt[k] != P) done = 1'b0;
    if (done) begin
      for (int i = 0; i < N; i++) exp_q.push_back('{d: img[i], k: 2'(i / P), l: (i == N - 1)});
      for (int k = 0; k < K; k++) mcnt[k] = 0;
      held++;
    end
  endfunction

  function automatic logic [1:0][31:0] dir_data(input logic [3:0] v);
    logic [1:0][31:0] d = '0;
    int lane = 0;
    for (int k = 0; k < K; k++) if (v[k]) begin
      if (lane < PE) d[lane[0]] = 32'(k * 16 + mcnt[k]);
      lane++;
    end
    return d;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  logic        stalled = 1'b0, pl;
  logic [31:0] pd;
  logic [1:0]  pk;
  always @(negedge clk) begin
    if (res_n && stalled)
      check("stall_hold", 64'({out_valid, out_last, out_kernel, out_data}), 64'({1'b1, pl, pk, pd}));
    if (res_n && out_valid && out_ready)
      obs_q.push_back('{d: out_data, k: out_kernel, l: out_last, cyc: cyc});
    stalled <= res_n && out_valid && !out_ready;
    pd <= out_data; pk <= out_kernel; pl <= out_last;
  end

  task automatic drive(input logic [3:0] v, input logic [1:0][31:0] d);
    @(posedge clk); #1;
    in_valid = v;
    in_data  = d;
    case (rmode)
      0:       out_ready = 1'b1;
      1:       out_ready = !out_ready;
      2:       out_ready = 1'b0;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
    model_write(v, d);
  endtask

  task automatic send_directed_image();
    repeat (4) drive(4'b0011, dir_data(4'b0011));
    repeat (4) drive(4'b1100, dir_data(4'b1100));
  endtask

  task automatic send_random_image();
    int start = exp_q.size();
    int g = 0;
    while (exp_q.size() == start && g < 64) begin
      logic [3:0] v;
      int a, b;
      int cand[$];
      for (int k = 0; k < K; k++) if (mcnt[k] < P) cand.push_back(k);
      v = '0;
      a = $urandom_range(0, cand.size() - 1);
      v[cand[a][1:0]] = 1'b1;
      if (cand.size() > 1) begin
        b = $urandom_range(0, cand.size() - 2);
        if (b >= a) b++;
        v[cand[b][1:0]] = 1'b1;
      end
      drive(v, {$urandom, $urandom});
      g++;
    end
  endtask

  task automatic wait_drain(input string tag);
    int n = exp_q.size();
    int g = 0;
    while (obs_q.size() < n && g < 400) begin
      drive(4'b0, '0);
      g++;
    end
    repeat (3) drive(4'b0, '0);
    check({tag, "_count"}, 64'(obs_q.size()), 64'(n));
    for (int i = 0; i < n && i < obs_q.size(); i++)
      check($sformatf("%s_beat%0d", tag, i),
            64'({obs_q[i].k, obs_q[i].l, obs_q[i].d}), 64'({exp_q[i].k, exp_q[i].l, exp_q[i].d}));
  endtask

  task automatic clear_model();
    obs_q.delete();
    exp_q.delete();
    held = 0;
    for (int k = 0; k < K; k++) mcnt[k] = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    res_n = 1'b0;
    in_valid = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    res_n = 1'b1;
    clear_model();
    exp_ovf = 1'b0;
  endtask

  initial begin
    res_n = 1'b0; in_valid = '0; in_data = '0; out_ready = 1'b1;
    for (int k = 0; k < K; k++) mcnt[k] = 0;
    #2;
    check("rst_out_valid",  64'(out_valid),  64'(0));
    check("rst_out_last",   64'(out_last),   64'(0));
    check("rst_image_done", 64'(image_done), 64'(0));
    check("rst_overflow",   64'(overflow),   64'(0));
    check("rst_out_data",   64'(out_data),   64'(0));
    check("rst_out_kernel", 64'(out_kernel), 64'(0));
    #20;
    @(negedge clk) res_n = 1'b1;

    // Directed image, checking the t / t+1 / t+2 timing of done and valid.
    rmode = 0;
    send_directed_image();
    check("t1_done_at_t", 64'(image_done), 64'(0));
    drive(4'b0, '0);
    check("t1_done_pulse", 64'(image_done), 64'(1));
    check("t1_valid_at_t1", 64'(out_valid), 64'(0));
    drive(4'b0, '0);
    check("t1_valid_at_t2", 64'(out_valid), 64'(1));
    check("t1_done_cleared", 64'(image_done), 64'(0));
    wait_drain("t1");
    if (obs_q.size() == N) check("t1_last_value", 64'({obs_q[N-1].l, obs_q[N-1].d}), 64'({1'b1, 32'd51}));
    check("t1_overflow", 64'(overflow), 64'(exp_ovf));
    clear_model();

    // Same stream under toggling backpressure.
    rmode = 1;
    send_directed_image();
    wait_drain("t2");
    clear_model();

    // Two back-to-back images, no bubble between them.
    rmode = 0;
    send_random_image();
    send_random_image();
    wait_drain("t3");
    if (obs_q.size() == 2 * N) check("t3_no_bubble", 64'(obs_q[2*N-1].cyc - obs_q[0].cyc), 64'(2 * N - 1));
    check("t3_overflow", 64'(overflow), 64'(exp_ovf));
    clear_model();

    // Reset mid-drain, then a fresh image.
    send_random_image();
    begin
      int g = 0;
      while (obs_q.size() < 5 && g < 100) begin drive(4'b0, '0); g++; end
    end
    check("t4_reached_5", 64'(obs_q.size() >= 5), 64'(1));
    #1 res_n = 1'b0;
    #1;
    check("t4_rst_valid", 64'(out_valid), 64'(0));
    check("t4_rst_last",  64'(out_last),  64'(0));
    in_valid = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) res_n = 1'b1;
    clear_model();
    send_random_image();
    wait_drain("t4");
    clear_model();

    // Three set bits on a two-lane bus: kernel 2 dropped.
    check("t5_ovf_before", 64'(overflow), 64'(0));
    drive(4'b0111, {$urandom, $urandom});
    check("t5_ovf_same_cycle", 64'(overflow), 64'(0));
    send_random_image();
    check("t5_ovf_set", 64'(overflow), 64'(exp_ovf));
    wait_drain("t5");
    do_reset();
    check("t5_ovf_after_reset", 64'(overflow), 64'(0));

    // Three images with no drain: third image is dropped.
    rmode = 2;
    send_random_image();
    send_random_image();
    check("t6_ovf_two_images", 64'(overflow), 64'(exp_ovf));
    drive(4'b0011, {$urandom, $urandom});
    drive(4'b0011, {$urandom, $urandom});
    check("t6_ovf_first_drop", 64'(overflow), 64'(exp_ovf));
    repeat (3) drive(4'b0011, {$urandom, $urandom});
    repeat (3) drive(4'b1100, {$urandom, $urandom});
    check("t6_ovf_sticky", 64'(overflow), 64'(1));
    rmode = 0;
    wait_drain("t6");
    check("t6_idle_after", 64'(out_valid), 64'(0));
    clear_model();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
